// File: rtl/uart_rx_block_if.sv
// Host-side handshake of the UART receiver: the parallel byte, its valid/read pair and the status flags.
// The receiver drives everything except rx_rd, which comes from the host.
interface uart_rx_block_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_rd;
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_busy;
    logic                 frame_err;
    logic                 overrun;

    modport master (
        output rx_rd,
        input  rx_data, rx_valid, rx_busy, frame_err, overrun
    );

    modport slave (
        input  rx_rd,
        output rx_data, rx_valid, rx_busy, frame_err, overrun
    );
endinterface

// File: rtl/uart_rx_block.sv
// 16x-oversampling UART receiver: 1 start, DATA_BITS data, 1 stop bit, 3-sample majority per bit,
// with a valid/read byte handshake and sticky framing-error and overrun flags.
module uart_rx_block #(
    parameter int DATA_BITS = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic            clk16,
    input  logic            rst_n,
    input  logic            serial_in,
    uart_rx_block_if.slave  bus
);
    localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t               state, state_next;
    logic                 sync1, s_in, s_prev;
    logic [3:0]           cnt, cnt_next;
    logic                 samp7, samp8, maj;
    logic                 shift_en, byte_done, frame_bad;
    logic [IW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg, shreg_next;

    // s_prev is one more stage so IDLE can see a genuine high-to-low transition of s_in.
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            s_in   <= 1'b1;
            s_prev <= 1'b1;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            sync1  <= serial_in;
            s_in   <= sync1;
            s_prev <= s_in;
        end
    end

    assign maj = (samp7 & samp8) | (samp7 & s_in) | (samp8 & s_in);

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // The counter sits at 0 in IDLE, so the edge-detect cycle is count 0 of the start bit.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        state_next = state;
        cnt_next   = cnt + 4'd1;
        shift_en   = 1'b0;
        byte_done  = 1'b0;
        frame_bad  = 1'b0;
        case (state)
            IDLE: begin
                cnt_next = 4'd0;
                if (s_prev && !s_in) begin
                    state_next = START;
                    cnt_next   = 4'd1;
                end
            end
            START: begin
                if (cnt == 4'd9) begin
                    if (maj) begin
                        state_next = IDLE;
                        cnt_next   = 4'd0;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                if (cnt == 4'd9) begin
                    shift_en = 1'b1;
                    if (bit_idx == IW'(DATA_BITS - 1)) state_next = STOP;
                end
            end
            STOP: begin
                if (cnt == 4'd9) begin
                    if (maj) begin
                        byte_done  = 1'b1;
                        state_next = IDLE;
                        cnt_next   = 4'd0;
                    end else begin
                        frame_bad  = 1'b1;
                        state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_next = 4'd0;
                if (s_in) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_comb begin
        if (LSB_FIRST) shreg_next = {maj, shreg[DATA_BITS-1:1]};
        else           shreg_next = {shreg[DATA_BITS-2:0], maj};
    end

    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            samp7   <= 1'b1;
            samp8   <= 1'b1;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            if (cnt == 4'd7) samp7 <= s_in;
            if (cnt == 4'd8) samp8 <= s_in;
            if (state == START) bit_idx <= '0;
            else if (shift_en)  bit_idx <= bit_idx + IW'(1);
            if (shift_en) shreg <= shreg_next;
        end
    end

    // A read in the completion cycle frees the holding register, so the new byte is taken, not dropped.
    always_ff @(posedge clk16 or negedge rst_n) begin
        if (!rst_n) begin
            bus.rx_data   <= '0;
            bus.rx_valid  <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else begin
            if (byte_done && (!bus.rx_valid || bus.rx_rd)) begin
                bus.rx_data  <= shreg;
                bus.rx_valid <= 1'b1;
            end else if (bus.rx_rd) begin
                bus.rx_valid <= 1'b0;
            end
            bus.overrun   <= (byte_done && bus.rx_valid && !bus.rx_rd) || (bus.overrun && !bus.rx_rd);
            bus.frame_err <= frame_bad || (bus.frame_err && !bus.rx_rd);
        end
    end

    assign bus.rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_block.sv
// Self-checking bench for uart_rx_block: directed corner cases, a frame table and a randomized
// run compared against a frame-level model of the host-visible state.
module tb_uart_rx_block;
    logic clk16;
    logic rst_n;
    logic serial_in;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_block_if #(.DATA_BITS(8)) bus ();

    uart_rx_block #(.DATA_BITS(8), .LSB_FIRST(1'b0)) dut (
        .clk16     (clk16),
        .rst_n     (rst_n),
        .serial_in (serial_in),
        .bus       (bus)
    );

    initial clk16 = 1'b0;
    always #5 clk16 = ~clk16;

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         rd_first;
        logic [7:0] exp_data;
        bit         exp_valid;
        bit         exp_ferr;
        bit         exp_ovr;
    } vec_t;

    vec_t vecs[8];

    // Frame-level reference of the host-visible state.
    logic [7:0] m_data;
    bit         m_valid, m_ferr, m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk16);
        #1;
    endtask

    // Called 1 ns after a rising edge; data goes out MSB first, 16 clk16 per bit.
    task automatic send_frame(input logic [7:0] b, input bit stop_bit);
        serial_in = 1'b0;
        tick(16);
        for (int i = 7; i >= 0; i--) begin
            serial_in = b[i];
            tick(16);
        end
        serial_in = stop_bit;
        tick(16);
    endtask

    task automatic read_pulse();
        bus.rx_rd = 1'b1;
        tick(1);
        bus.rx_rd = 1'b0;
    endtask

    task automatic check_all(input string tag, input logic [7:0] d, input bit v, input bit fe,
                             input bit ov, input bit busy);
        check({tag, " rx_data"},   32'(bus.rx_data),   32'(d));
        check({tag, " rx_valid"},  32'(bus.rx_valid),  32'(v));
        check({tag, " frame_err"}, 32'(bus.frame_err), 32'(fe));
        check({tag, " overrun"},   32'(bus.overrun),   32'(ov));
        check({tag, " rx_busy"},   32'(bus.rx_busy),   32'(busy));
    endtask

    // Sends one frame (releasing the line after a bad stop) and updates the model.
    task automatic model_frame(input logic [7:0] b, input bit stop_ok, input bit rd_first);
        if (rd_first) begin
            read_pulse();
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            m_ovr   = 1'b0;
            tick(2);
        end
        send_frame(b, stop_ok);
        if (!stop_ok) begin
            m_ferr    = 1'b1;
            serial_in = 1'b1;
        end else if (!m_valid) begin
            m_data  = b;
            m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
        tick(4);
    endtask

    initial begin
        int  lat;
        rst_n     = 1'b0;
        serial_in = 1'b1;
        bus.rx_rd = 1'b0;
        m_data = '0; m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;

        vecs[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h5A, 1'b1, 1'b1, 8'h5A, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{8'h00, 1'b1, 1'b0, 8'h5A, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{8'h81, 1'b1, 1'b0, 8'h81, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{8'h7E, 1'b1, 1'b1, 8'h7E, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h01, 1'b0, 1'b0, 8'h7E, 1'b1, 1'b1, 1'b0};

        tick(3);
        check_all("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick(5);

        // Latency from the serial_in fall to rx_valid, then a read.
        lat = -1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int n = 1; n <= 200; n++) begin
                    tick(1);
                    if (bus.rx_valid && lat < 0) lat = n;
                end
            end
        join
        check("latency_a5", 32'(lat), 32'd156);
        check_all("frame_a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
        read_pulse();
        check_all("read_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Five-cycle low glitch: START must abort at the mid-bit vote.
        tick(5);
        serial_in = 1'b0;
        tick(5);
        serial_in = 1'b1;
        check("glitch_busy", 32'(bus.rx_busy), 32'd1);
        tick(20);
        check_all("glitch_end", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

        // Bad stop bit, line held low, then a clean frame.
        send_frame(8'h3C, 1'b0);
        tick(40);
        check_all("break_low", 8'hA5, 1'b0, 1'b1, 1'b0, 1'b1);
        serial_in = 1'b1;
        tick(5);
        check("break_exit_busy", 32'(bus.rx_busy), 32'd0);
        send_frame(8'h81, 1'b1);
        check_all("after_break", 8'h81, 1'b1, 1'b1, 1'b0, 1'b0);
        read_pulse();
        check_all("read_81", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0);

        // Back-to-back frames with no read: the second byte is dropped.
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check_all("overrun", 8'h11, 1'b1, 1'b0, 1'b1, 1'b0);
        read_pulse();
        check_all("read_overrun", 8'h11, 1'b0, 1'b0, 1'b0, 1'b0);

        // Read strobe in the completion cycle of the second byte.
        tick(3);
        send_frame(8'h11, 1'b1);
        fork
            send_frame(8'h22, 1'b1);
            begin
                tick(155);
                bus.rx_rd = 1'b1;
                tick(1);
                bus.rx_rd = 1'b0;
            end
        join
        check_all("rd_at_done", 8'h22, 1'b1, 1'b0, 1'b0, 1'b0);

        // Reset during data bit 4 of 0xFF, then a normal frame.
        fork
            send_frame(8'hFF, 1'b1);
            begin
                tick(87);
                check("pre_reset_busy", 32'(bus.rx_busy), 32'd1);
                check("pre_reset_valid", 32'(bus.rx_valid), 32'd1);
                tick(1);
                rst_n = 1'b0;
                #1;
                check_all("mid_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
                tick(3);
                rst_n = 1'b1;
            end
        join
        tick(5);
        check("post_reset_idle", 32'(bus.rx_busy), 32'd0);
        send_frame(8'h5A, 1'b1);
        check_all("post_reset_5a", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
        read_pulse();
        tick(3);

        // Frame table from a clean state.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].rd_first) begin
                read_pulse();
                tick(2);
            end
            send_frame(vecs[i].data, vecs[i].stop_ok);
            serial_in = 1'b1;
            tick(4);
            check_all($sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_valid,
                      vecs[i].exp_ferr, vecs[i].exp_ovr, 1'b0);
        end

        // Randomized frames against the frame-level model.
        read_pulse();
        tick(2);
        m_data  = bus.rx_data;
        m_valid = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
        check_all("rand_start", m_data, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            logic [7:0] b;
            bit stop_ok, rd_first;
            b        = 8'($urandom_range(0, 255));
            stop_ok  = ($urandom_range(0, 4) != 0);
            rd_first = ($urandom_range(0, 1) == 1);
            model_frame(b, stop_ok, rd_first);
            check_all($sformatf("rand%0d", i), m_data, m_valid, m_ferr, m_ovr, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx_block.md
Name: uart_rx_block

Overview:
- 16x-oversampling UART receiver: the receive-side counterpart of the chip's transmitter, on the same clk16 domain.
- Recovers 1-start / DATA_BITS-data / 1-stop frames from the serial line and delivers parallel bytes through a valid/read handshake.
- Reports framing errors and overruns.
- Sits between the RX pad and the host/register interface.

Parameters:
- DATA_BITS, 8, data bits per frame.
- LSB_FIRST, 0, 0 = first data bit received is MSB (matches chip transmitter), 1 = LSB first.

Ports:
- clk16  input  1  16x baud clock
- rst_n  input  1  reset
- serial_in  input  1  asynchronous serial line, idle high
- rx_rd  input  1  host read strobe, one clk16 cycle, clears rx_valid
- rx_data  output  DATA_BITS  last accepted byte
- rx_valid  output  1  rx_data holds an unread byte
- rx_busy  output  1  frame in progress (state != IDLE)
- frame_err  output  1  sticky; stop bit sampled low
- overrun  output  1  sticky; byte dropped because the previous byte was unread

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; clock is clk16.
- Reset values: rx_data=0, rx_valid=0, rx_busy=0, frame_err=0, overrun=0, state IDLE, sample counter 0, synchroniser flops 1.
- Synchroniser: serial_in passes through a 2-flop synchroniser to give s_in. All decisions use s_in, which adds 2 cycles of latency.
- Sample counter: 4-bit, wraps 15->0 each bit period.
- Bit decision: 3-sample majority of s_in at counts 7, 8, 9, decided at count 9.
- IDLE:
  - Waits for s_in 1->0; on that cycle counter is cleared and state goes to START.
  - A low level without a preceding high does not start a frame.
- START:
  - At count 9, majority 0 -> DATA, bit index 0.
  - Majority 1 -> false start, return to IDLE with no flag change.
- DATA:
  - At count 9 of each bit period, shift the majority bit into the shift register.
  - LSB_FIRST=0: shift toward MSB, so the first bit lands in bit DATA_BITS-1.
  - LSB_FIRST=1: shift toward LSB.
  - After bit DATA_BITS-1, go to STOP.
- STOP, at count 9:
  - Majority 1 -> byte complete, go to IDLE next cycle. IDLE accepts a new falling edge immediately, i.e. within the second half of the stop bit.
  - Majority 0 -> frame_err=1, byte discarded (rx_data, rx_valid unchanged), go to BREAK.
- BREAK: waits for s_in=1, then IDLE.
- Completion timing: rx_valid rises on the clk16 edge after the stop decision. That is 154 cycles after the s_in falling edge, or 156 after the serial_in edge.
- Byte completion with rx_valid=0: rx_data loaded, rx_valid=1.
- Byte completion with rx_valid=1 and no rx_rd in the same cycle: new byte dropped, rx_data keeps the old byte, overrun=1.
- Byte completion and rx_rd in the same cycle: new byte loaded, rx_valid stays 1, no overrun.
- rx_rd with no completion: rx_valid=0, rx_data unchanged.
- Clearing flags: a rx_rd strobe clears frame_err and overrun in the cycle after the read; the byte just read is unaffected. If a new error occurs in the same cycle as rx_rd, the new error wins (flag stays 1).
- Reset mid-frame: immediate return to reset values; the partial byte is lost. After release, receiving resumes only after s_in has been seen high (IDLE edge rule).
- rx_busy = 1 in START, DATA, STOP and BREAK.

Test Plan:
- Send 0xA5 (LSB_FIRST=0), 16 clk16 per bit -> rx_valid=1 exactly 156 cycles after the serial_in fall, rx_data=0xA5, frame_err=0; rx_rd -> rx_valid=0.
- Low glitch of 5 cycles on the idle line -> START aborts at count 9, no rx_valid, rx_busy back to 0, flags 0.
- Send 0x3C with stop bit forced 0, line held low 40 cycles, then high -> frame_err=1, rx_valid=0, state BREAK until line high; next 0x81 frame received correctly.
- Send 0x11 then 0x22 back-to-back with no rx_rd -> rx_data=0x11, overrun=1; rx_rd -> rx_valid=0, overrun=0.
- Send 0x11, then 0x22 with rx_rd asserted in the 0x22 completion cycle -> rx_data=0x22, rx_valid=1, overrun=0.
- Assert rst_n low during data bit 4 of 0xFF -> all outputs 0 immediately; after release, send 0x5A -> rx_data=0x5A, no flags.
